seg_msg_sequencer: RTL

- Controller that sequences the message-letter ROM feeding the 7-segment output register.
- Produces the letter index and a one-cycle load strobe. The display datapath registers the segment pattern for that index on the strobe.
- Advance sources: debounced push-button in manual mode, or a programmable timer in auto-scroll mode. In auto mode the button toggles pause/resume.
- Sits between the raw ui_in pins and the letter ROM / segment output register. This replaces direct clocking of the display from a button pin.

---
 rtl/seg_msg_if.sv | 24 ++
 rtl/seg_msg_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seg_msg_if.sv
// Handshake bundle between the raw user pins / period setting and the
// letter-ROM + segment-register datapath.
interface seg_msg_if #(
  parameter int IDX_W = 4,
  parameter int PER_W = 8
);
  logic             btn_raw;
  logic             auto_en;
  logic [PER_W-1:0] period;
  logic [IDX_W-1:0] seg_idx;
  logic             seg_load;
  logic             wrap;
  logic             paused;

  modport master (
    output btn_raw, auto_en, period,
    input  seg_idx, seg_load, wrap, paused
  );

  modport slave (
    input  btn_raw, auto_en, period,
    output seg_idx, seg_load, wrap, paused
  );
endinterface

// File: rtl/seg_msg_sequencer.sv
// Sequences the message-letter index for the 7-segment display: manual stepping
// from a debounced button, or timed auto-scroll with button pause/resume.
module seg_msg_sequencer #(
  parameter int MSG_LEN    = 14,
  parameter int IDX_W      = 4,
  parameter int DEB_CYCLES = 50000,
  parameter int PRESCALE   = 10000,
  parameter int PER_W      = 8
) (
  input  logic     clk,
  input  logic     rst,
  seg_msg_if.slave bus
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_AUTO   = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

  // Bit 0 = button, bit 1 = mode select; both arrive asynchronously.
  logic [1:0] sync_in;
  logic [1:0] sync_out;
  assign sync_in = {bus.auto_en, bus.btn_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= sync_in[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_out[gi] = s2_reg;
    end
  endgenerate

  logic btn_s;
  logic auto_s;
  assign btn_s  = sync_out[0];
  assign auto_s = sync_out[1];

  logic [DEB_W-1:0] deb_cnt_reg;
  logic             btn_acc_reg;
  logic             press_reg;

  // A new level is accepted only after it has held for DEB_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_reg <= '0;
      btn_acc_reg <= 1'b0;
      press_reg   <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      if (btn_s == btn_acc_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
        deb_cnt_reg <= '0;
        btn_acc_reg <= btn_s;
        press_reg   <= btn_s;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
      end
    end
  end

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic             advance;
  logic [PRE_W-1:0] pre_cnt_reg;
  logic [PER_W-1:0] per_cnt_reg;
  logic             tick;
  logic             timer_adv;
  logic             run;
  logic [PER_W:0]   period_eff;
  logic [PER_W:0]   per_inc;

  assign tick       = (state_reg == ST_AUTO) && (pre_cnt_reg == PRE_W'(PRESCALE - 1));
  assign period_eff = (bus.period == '0) ? (PER_W+1)'(1) : {1'b0, bus.period};
  assign per_inc    = {1'b0, per_cnt_reg} + (PER_W+1)'(1);
  assign timer_adv  = tick && (per_inc >= period_eff);

  // Mode change outranks press, which outranks the timer.
  always_comb begin
    state_next = state_reg;
    advance    = 1'b0;
    case (state_reg)
      ST_MANUAL: begin
        if (auto_s)         state_next = ST_AUTO;
        else if (press_reg) advance    = 1'b1;
      end
      ST_AUTO: begin
        if (!auto_s)        state_next = ST_MANUAL;
        else if (press_reg) state_next = ST_PAUSED;
        else if (timer_adv) advance    = 1'b1;
      end
      ST_PAUSED: begin
        if (!auto_s)        state_next = ST_MANUAL;
        else if (press_reg) state_next = ST_AUTO;
      end
      default: state_next = ST_MANUAL;
    endcase
  end

  // Counters only run while staying in AUTO, so every entry starts from zero.
  assign run = (state_reg == ST_AUTO) && (state_next == ST_AUTO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_reg <= '0;
      per_cnt_reg <= '0;
    end else if (!run) begin
      pre_cnt_reg <= '0;
      per_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= tick ? '0 : pre_cnt_reg + PRE_W'(1);
      if (tick) per_cnt_reg <= timer_adv ? '0 : per_inc[PER_W-1:0];
    end
  end

  logic [IDX_W-1:0] seg_idx_reg;
  logic             seg_load_reg;
  logic             wrap_reg;
  logic             idx_last;

  assign idx_last = (seg_idx_reg == IDX_W'(MSG_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_MANUAL;
      seg_idx_reg  <= '0;
      seg_load_reg <= 1'b0;
      wrap_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      seg_load_reg <= advance;
      wrap_reg     <= advance && idx_last;
      if (advance) seg_idx_reg <= idx_last ? '0 : seg_idx_reg + IDX_W'(1);
    end
  end

  assign bus.seg_idx  = seg_idx_reg;
  assign bus.seg_load = seg_load_reg;
  assign bus.wrap     = wrap_reg;
  assign bus.paused   = (state_reg == ST_PAUSED);

endmodule
